// File: rtl/led_chaser_pkg.sv
// rtl/led_chaser_pkg.sv - shared mode and FSM state encodings for the LED chaser
package led_chaser_pkg;

  // Movement modes as presented on the mode input; encoding 3 is folded into WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_t;

  // Chaser control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Map the raw two-bit mode input onto a legal mode.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    return (raw == 2'd3) ? MODE_WRAP : mode_t'(raw);
  endfunction

endpackage

// File: rtl/pos_onehot_dec.sv
// rtl/pos_onehot_dec.sv - registered one-hot decode of a position index
module pos_onehot_dec #(
  parameter int N_POS = 9,
  parameter int POS_W = $clog2(N_POS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] pos,
  output logic [N_POS-1:0] onehot
);

  logic [N_POS-1:0] dec;

  // Decode the index; an index outside 0..N_POS-1 lights nothing.
  always_comb begin
    dec = '0;
    for (int i = 0; i < N_POS; i++) begin
      if (int'(pos) == i) dec[i] = 1'b1;
    end
  end

  // Register the decode; reset shows position 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) onehot <= N_POS'(1);
    else     onehot <= dec;
  end

endmodule

// File: rtl/led_chaser.sv
// rtl/led_chaser.sv - LED chaser with wrap/bounce/oneshot motion and stop-on-target game
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int N_POS = 9,
  parameter int POS_W = $clog2(N_POS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             stop_req,
  input  logic [POS_W-1:0] target,
  output logic [POS_W-1:0] position,
  output logic [N_POS-1:0] led,
  output logic             running,
  output logic             hit_valid,
  output logic             hit,
  output logic             done
);

  localparam logic [POS_W-1:0] LAST = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] ONE  = POS_W'(1);

  state_t           state, state_n;
  mode_t            mode_r, mode_n;
  logic             dir_r, dir_n;
  logic [POS_W-1:0] pos_n, home, far_end, step_pos;
  logic             step_dir, match;
  logic             pend, pend_n, hit_cap, hit_cap_n;
  logic             hit_valid_n, hit_n, done_n;

  assign home    = (dir == DIR_DOWN) ? LAST : '0;
  assign far_end = (dir_r == DIR_DOWN) ? '0 : LAST;
  assign match   = (int'(target) < N_POS) && (position == target);
  assign running = (state == ST_RUN);

  // Where one step would take us from the current position and direction.
  always_comb begin
    step_pos = position;
    step_dir = dir_r;
    if (mode_r == MODE_BOUNCE) begin
      if (dir_r == DIR_UP) begin
        if (position == LAST) begin
          step_pos = position - ONE;
          step_dir = DIR_DOWN;
        end else begin
          step_pos = position + ONE;
        end
      end else begin
        if (position == '0) begin
          step_pos = position + ONE;
          step_dir = DIR_UP;
        end else begin
          step_pos = position - ONE;
        end
      end
    end else if (dir_r == DIR_UP) begin
      step_pos = (position == LAST) ? '0 : position + ONE;
    end else begin
      step_pos = (position == '0) ? LAST : position - ONE;
    end
  end

  // Next-state and next-output logic; a stop result is reported one cycle after HOLD is entered.
  always_comb begin
    state_n     = state;
    pos_n       = position;
    dir_n       = dir_r;
    mode_n      = mode_r;
    pend_n      = pend;
    hit_cap_n   = hit_cap;
    hit_valid_n = 1'b0;
    hit_n       = hit;
    done_n      = 1'b0;
    case (state)
      ST_IDLE: begin
        pos_n  = home;
        dir_n  = dir;
        mode_n = decode_mode(mode);
        pend_n = 1'b0;
        if (start) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (!start) begin
          state_n = ST_IDLE;
          pos_n   = home;
          pend_n  = 1'b0;
        end else if (stop_req) begin
          state_n   = ST_HOLD;
          pend_n    = 1'b1;
          hit_cap_n = match;
        end else if (step) begin
          pos_n = step_pos;
          dir_n = step_dir;
          if (mode_r == MODE_ONESHOT && step_pos == far_end) begin
            state_n = ST_HOLD;
            done_n  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!start) begin
          state_n = ST_IDLE;
          pos_n   = home;
          pend_n  = 1'b0;
        end else if (pend) begin
          hit_valid_n = 1'b1;
          hit_n       = hit_cap;
          pend_n      = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      position  <= '0;
      dir_r     <= DIR_UP;
      mode_r    <= MODE_WRAP;
      pend      <= 1'b0;
      hit_cap   <= 1'b0;
      hit_valid <= 1'b0;
      hit       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      position  <= pos_n;
      dir_r     <= dir_n;
      mode_r    <= mode_n;
      pend      <= pend_n;
      hit_cap   <= hit_cap_n;
      hit_valid <= hit_valid_n;
      hit       <= hit_n;
      done      <= done_n;
    end
  end

  pos_onehot_dec #(.N_POS(N_POS), .POS_W(POS_W)) u_dec (
    .clk    (clk),
    .rst    (rst),
    .pos    (position),
    .onehot (led)
  );

endmodule

// File: tb/tb_led_chaser.sv
// tb/tb_led_chaser.sv - self-checking bench for led_chaser with a step-count reference model
module tb_led_chaser;

  localparam int NA = 9;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, step = 1'b0, dir = 1'b0, stop_req = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] target = 4'd0;

  logic [3:0] pos_a;
  logic [8:0] led_a;
  logic       run_a, hv_a, hit_a, done_a;
  logic [1:0] pos_b;
  logic [3:0] led_b;
  logic       run_b, hv_b, hit_b, done_b;

  always #5 clk = ~clk;

  led_chaser #(.N_POS(NA)) dut_a (
    .clk(clk), .rst(rst), .start(start), .step(step), .mode(mode), .dir(dir),
    .stop_req(stop_req), .target(target), .position(pos_a), .led(led_a),
    .running(run_a), .hit_valid(hv_a), .hit(hit_a), .done(done_a)
  );

  led_chaser #(.N_POS(NB)) dut_b (
    .clk(clk), .rst(rst), .start(start), .step(step), .mode(mode), .dir(dir),
    .stop_req(stop_req), .target(target[1:0]), .position(pos_b), .led(led_b),
    .running(run_b), .hit_valid(hv_b), .hit(hit_b), .done(done_b)
  );

  // Reference model: position is a pure function of steps taken since the run began.
  typedef struct {
    int phase;  // 0 idle, 1 run, 2 hold
    int k;
    int dir0;
    int mode;
    int pos;
    int led;
    bit hv;
    bit hit;
    bit done;
    bit pend;
    bit hcap;
  } model_t;

  model_t ma, mb;
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     chk_en = 1'b0;

  int wrap_exp[10]  = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 1};
  int bounce_exp[8] = '{1, 2, 3, 2, 1, 0, 1, 2};

  function automatic int home_of(int n, bit d);
    return d ? n - 1 : 0;
  endfunction

  function automatic int pos_at(int n, int md, int d0, int k);
    int u, per;
    if (md == 1) begin
      per = 2 * (n - 1);
      u = k % per;
      if (u >= n) u = per - u;
    end else if (md == 2) begin
      u = (k < n - 1) ? k : n - 1;
    end else begin
      u = k % n;
    end
    return (d0 != 0) ? n - 1 - u : u;
  endfunction

  function automatic model_t reset_m();
    model_t m;
    m = '{default: 0};
    return m;
  endfunction

  function automatic model_t mstep(model_t m, int n, bit st, bit sp, int md, bit d, bit sr, int tg);
    model_t r;
    r = m;
    r.led  = m.pos;
    r.hv   = 1'b0;
    r.done = 1'b0;
    if (m.phase == 0) begin
      r.pos  = home_of(n, d);
      r.dir0 = d;
      r.mode = md;
      r.k    = 0;
      r.pend = 1'b0;
      if (st) r.phase = 1;
    end else if (!st) begin
      r.phase = 0;
      r.pos   = home_of(n, d);
      r.pend  = 1'b0;
    end else if (m.phase == 1) begin
      if (sr) begin
        r.phase = 2;
        r.pend  = 1'b1;
        r.hcap  = (tg < n) && (tg == m.pos);
      end else if (sp) begin
        r.k   = m.k + 1;
        r.pos = pos_at(n, m.mode, m.dir0, r.k);
        if (m.mode == 2 && r.k == n - 1) begin
          r.phase = 2;
          r.done  = 1'b1;
        end
      end
    end else if (m.pend) begin
      r.hv   = 1'b1;
      r.hit  = m.hcap;
      r.pend = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = reset_m();
      mb = reset_m();
    end else begin
      ma = mstep(ma, NA, start, step, int'(mode), dir, stop_req, int'(target));
      mb = mstep(mb, NB, start, step, int'(mode), dir, stop_req, int'(target[1:0]));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, both DUTs against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pos_a",  pos_a,  ma.pos);
      chk("led_a",  led_a,  32'(1) << ma.led);
      chk("run_a",  run_a,  ma.phase == 1);
      chk("hv_a",   hv_a,   ma.hv);
      chk("hit_a",  hit_a,  ma.hit);
      chk("done_a", done_a, ma.done);
      chk("pos_b",  pos_b,  mb.pos);
      chk("led_b",  led_b,  32'(1) << mb.led);
      chk("run_b",  run_b,  mb.phase == 1);
      chk("hv_b",   hv_b,   mb.hv);
      chk("hit_b",  hit_b,  mb.hit);
      chk("done_b", done_b, mb.done);
    end
  end

  task automatic tick(input bit st, input bit sp, input bit sr);
    start    = st;
    step     = sp;
    stop_req = sr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int prev, dones, hvs;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pos",  pos_a, 0);
    chk("rst_led",  led_a, 1);
    chk("rst_run",  run_a, 0);
    chk("rst_hv",   hv_a, 0);
    chk("rst_hit",  hit_a, 0);
    chk("rst_done", done_a, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Wrap upward on the 9-position chaser.
    mode = 2'd0; dir = 1'b0;
    tick(1, 0, 0);
    chk("wrap_running", run_a, 1);
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 0);
      chk("wrap_pos", pos_a, wrap_exp[i]);
      chk("wrap_led_lag", led_a, 32'(1) << prev);
      prev = wrap_exp[i];
    end
    tick(0, 0, 0);

    // Bounce on the 4-position chaser.
    mode = 2'd1;
    tick(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 0);
      chk("bounce_pos", pos_b, bounce_exp[i]);
    end
    tick(0, 0, 0);

    // Oneshot downward from 8.
    mode = 2'd2; dir = 1'b1;
    tick(0, 0, 0);
    chk("os_home", pos_a, 8);
    tick(1, 0, 0);
    dones = 0;
    for (int i = 0; i < 11; i++) begin
      tick(1, 1, 0);
      dones += int'(done_a);
      if (i == 7) chk("os_done_at_end", done_a, 1);
    end
    chk("os_done_count", dones, 1);
    chk("os_final_pos", pos_a, 0);
    chk("os_not_running", run_a, 0);

    // Stop together with the step that would move 5 -> 6.
    tick(0, 0, 0);
    mode = 2'd0; dir = 1'b0; target = 4'd5;
    tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (5) tick(1, 1, 0);
    chk("pre_stop_pos", pos_a, 5);
    tick(1, 1, 1);
    chk("stop_frozen", pos_a, 5);
    chk("stop_hv_not_yet", hv_a, 0);
    tick(1, 0, 0);
    chk("stop_hv", hv_a, 1);
    chk("stop_hit", hit_a, 1);
    tick(1, 1, 0);
    chk("hold_pos", pos_a, 5);
    chk("hv_one_cycle", hv_a, 0);
    chk("hit_held", hit_a, 1);

    // Stop at 4 misses.
    tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (4) tick(1, 1, 0);
    tick(1, 0, 1);
    tick(1, 0, 0);
    chk("miss_hv", hv_a, 1);
    chk("miss_hit", hit_a, 0);

    // Drop start in HOLD, then stop requests in IDLE are ignored.
    dir = 1'b1;
    tick(0, 0, 0);
    chk("hold_to_idle_home", pos_a, 8);
    chk("hold_to_idle_run", run_a, 0);
    hvs = 0;
    repeat (4) begin
      tick(0, 1, 1);
      hvs += int'(hv_a);
    end
    chk("idle_stop_no_hv", hvs, 0);

    // A pending result is cancelled when start drops.
    dir = 1'b0;
    tick(1, 0, 0);
    tick(1, 1, 0);
    tick(1, 0, 1);
    tick(0, 0, 0);
    chk("cancel_hv_a", hv_a, 0);
    tick(0, 0, 0);
    chk("cancel_hv_b", hv_a, 0);

    // Asynchronous reset mid-run at position 6.
    tick(1, 0, 0);
    repeat (6) tick(1, 1, 0);
    chk("pre_rst_pos", pos_a, 6);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_pos", pos_a, 0);
    chk("async_rst_led", led_a, 1);
    chk("async_rst_run", run_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_idle", run_a, 0);
    tick(1, 0, 0);
    chk("post_rst_start", run_a, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      mode   = 2'($urandom_range(0, 3));
      dir    = 1'($urandom_range(0, 1));
      target = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        tick(1, 0, 0);
        rst = 1'b0;
      end
      tick($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
